pwm_drv: RTL and testbench
==========================

Name: pwm_drv

Overview:
- Downstream output stage of cbc_dig. Consumes the signed 14-bit duty word and its write strobe from the digital control loop, and produces the complementary motor-drive PWM pair CH_A/CH_B.
- pwm_monitor observes CH_A/CH_B on the bench.
- The block double-buffers duty so that updates land only on period boundaries, saturates the magnitude, and inserts dead time whenever drive direction reverses.

Parameters:
CNT_W, 13, period counter width; PWM period = 2^CNT_W clk cycles
DEADTIME, 16, clk cycles both channels are held low at the start of a direction-reversal period (must be < 2^CNT_W)

Ports:
clk  in  1  system clock
rst  in  1  reset
duty  in  14  signed two's-complement duty request from control loop
wrt_duty  in  1  one-cycle strobe; duty valid
CH_A  out  1  forward drive PWM
CH_B  out  1  reverse drive PWM
prd_strt  out  1  one-cycle pulse when counter = 0
duty_actv  out  14  duty value governing the current period

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state is sampled on posedge clk when rst=1.
- Reset values:
  - CH_A=0, CH_B=0, prd_strt=0, duty_actv=0.
  - pending=0, cnt=0, state=OFF, last_dir=NONE.
- Counter: cnt free-runs 0..2^CNT_W-1 and wraps to 0. prd_strt=1 in the cycle cnt==0; after reset, the first pulse occurs when cnt first reaches 0 again (i.e. 2^CNT_W cycles after reset release).
- Buffering:
  - wrt_duty=1 loads duty into pending. Multiple writes within a period: the last one wins.
  - At cnt==2^CNT_W-1, pending is copied to duty_actv, which governs the next period.
  - If wrt_duty coincides with cnt==2^CNT_W-1, the incoming duty goes directly to duty_actv (and to pending).
- Magnitude:
  - mag = |duty_actv|, 13 bits unsigned. duty_actv = -8192 (14'h2000) saturates to 8191.
  - on_cnt = mag >> (13-CNT_W).
  - A channel is on while cnt < on_cnt, so 100% duty is never reached. on_cnt = 0 gives no pulse.
- Direction: dir = A if duty_actv > 0, B if duty_actv < 0, NONE if duty_actv = 0.
- State machine, evaluated at each period boundary as the new duty_actv takes effect:
  - OFF: both outputs low. Entered when dir=NONE.
  - DEAD: entered when dir != NONE and dir != last_dir, with last_dir != NONE.
    - Both outputs low while cnt < DEADTIME.
    - At cnt == DEADTIME, go to DRIVE_A or DRIVE_B per dir. The channel then asserts only if cnt < on_cnt, so effective on-time = max(0, on_cnt - DEADTIME).
  - DRIVE_A: CH_A = (cnt < on_cnt), CH_B = 0. DRIVE_B is the mirror image.
  - Direct entry to DRIVE_x (no dead time) when dir equals last_dir, or when last_dir = NONE (first drive after reset).
- last_dir: updated to dir on entering DRIVE_x. It is not cleared by OFF periods, so A -> 0 -> B still incurs dead time.
- Invariant: CH_A & CH_B is never 1 in any cycle, including across reset and reversal.
- Outputs are registered: CH_x reflects the cnt value of the previous cycle, giving one cycle of latency from counter to pin; this is consistent for both edges.
- Reset mid-period: next cycle both outputs low, cnt=0, pending discarded; no glitch beyond the cycle in which rst is sampled.

Test Plan:
1. rst high 2 cycles -> CH_A=CH_B=0, duty_actv=0, no prd_strt while rst=1; first prd_strt 8192 cycles after release.
2. wrt_duty duty=14'h0800 mid-period -> duty_actv=0x0800 only after the next period boundary; the following period has CH_A high for exactly 2048 cycles, and CH_B stays 0.
3. duty=14'h3800 (-2048) after a +0x0800 period -> first period: both low for 16 cycles, then CH_B high for 2032 cycles. Next period: CH_B high for 2048 cycles.
4. duty=14'h2000 -> CH_B high for 8191 cycles per period (saturation); duty=14'h1FFF -> CH_A high for 8191 cycles.
5. wrt_duty asserted with duty=0x0100 on the cycle where cnt=8191 -> next period CH_A high for exactly 256 cycles. Two writes (0x0200, then 0x0300) in one period -> 0x0300 is used.
6. Sequence +0x0400, 0, -0x0400 -> middle period both low; third period has the 16-cycle dead band. Assert rst at cnt=100 in a drive period -> outputs 0 next cycle, and the counter restarts from 0.

Source files
------------

// File: rtl/pwm_drv_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_drv_if
//  Description : Duty-request and PWM-output bundle between the digital
//                control loop (master) and the PWM output stage (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_drv_if;
  logic [13:0] duty;       // signed duty request
  logic        wrt_duty;   // one-cycle strobe, duty valid
  logic        CH_A;       // forward drive PWM
  logic        CH_B;       // reverse drive PWM
  logic        prd_strt;   // pulse in the cycle the period counter is 0
  logic [13:0] duty_actv;  // duty governing the current period

  modport master (
    output duty,
    output wrt_duty,
    input  CH_A,
    input  CH_B,
    input  prd_strt,
    input  duty_actv
  );

  modport slave (
    input  duty,
    input  wrt_duty,
    output CH_A,
    output CH_B,
    output prd_strt,
    output duty_actv
  );
endinterface
`default_nettype wire

// File: rtl/pwm_drv.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_drv
//  Description : Complementary PWM output stage. Double-buffers the signed
//                duty word onto period boundaries, saturates its magnitude
//                and inserts a dead band whenever drive direction reverses.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_drv #(
  parameter int CNT_W    = 13,  // period = 2^CNT_W clk cycles
  parameter int DEADTIME = 16   // dead band length in clk cycles
) (
  input  logic     clk,
  input  logic     rst,
  pwm_drv_if.slave bus
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_DEAD    = 2'd1,
    ST_DRIVE_A = 2'd2,
    ST_DRIVE_B = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_A    = 2'd1,
    DIR_B    = 2'd2
  } dir_t;

  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEADTIME);

  // Drive direction implied by a signed duty word.
  function automatic dir_t dir_of(input logic [13:0] d);
    if (d == 14'd0)  dir_of = DIR_NONE;
    else if (d[13])  dir_of = DIR_B;
    else             dir_of = DIR_A;
  endfunction

  // |d| on 13 bits; the single unrepresentable value -8192 clamps to 8191.
  function automatic logic [12:0] mag_of(input logic [13:0] d);
    if (!d[13])              mag_of = d[12:0];
    else if (d == 14'h2000)  mag_of = 13'h1FFF;
    else                     mag_of = ~d[12:0] + 13'd1;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [13:0]      pending;
  logic [13:0]      duty_actv;
  logic             prd_strt;
  logic             ch_a;
  logic             ch_b;
  state_t           state;
  state_t           state_nxt;
  dir_t             last_dir;
  dir_t             last_dir_nxt;
  logic             ch_a_nxt;
  logic             ch_b_nxt;

  logic             period_end;
  logic [13:0]      duty_load;
  dir_t             new_dir;
  dir_t             cur_dir;
  logic [12:0]      mag;
  logic [CNT_W-1:0] on_cnt;
  logic             below_on;
  logic             in_dead;

  // A write landing on the last count bypasses pending so it is not lost.
  assign period_end = (cnt == CNT_LAST);
  assign duty_load  = bus.wrt_duty ? bus.duty : pending;
  assign new_dir    = dir_of(duty_load);
  assign cur_dir    = dir_of(duty_actv);
  assign mag        = mag_of(duty_actv);
  assign on_cnt     = mag[12 -: CNT_W];
  assign below_on   = (cnt < on_cnt);
  assign in_dead    = (cnt < DEAD_CNT);

  // Free-running period counter, duty double buffer and period-start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pending   <= '0;
      duty_actv <= '0;
      prd_strt  <= 1'b0;
    end else begin
      cnt      <= cnt + CNT_W'(1);
      prd_strt <= period_end;
      if (bus.wrt_duty) pending <= bus.duty;
      if (period_end)   duty_actv <= duty_load;
    end
  end

  // Drive state, remembered direction and registered channel outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_OFF;
      last_dir <= DIR_NONE;
      ch_a     <= 1'b0;
      ch_b     <= 1'b0;
    end else begin
      state    <= state_nxt;
      last_dir <= last_dir_nxt;
      ch_a     <= ch_a_nxt;
      ch_b     <= ch_b_nxt;
    end
  end

  // Channel levels for this count plus next state; each channel can only be
  // high in its own drive direction, so both can never be high together.
  always_comb begin
    state_nxt    = state;
    last_dir_nxt = last_dir;
    ch_a_nxt     = 1'b0;
    ch_b_nxt     = 1'b0;

    case (state)
      ST_DRIVE_A: ch_a_nxt = below_on;
      ST_DRIVE_B: ch_b_nxt = below_on;
      ST_DEAD: begin
        if (!in_dead) begin
          ch_a_nxt = below_on && (cur_dir == DIR_A);
          ch_b_nxt = below_on && (cur_dir == DIR_B);
        end
      end
      default: ;
    endcase

    // Dead band expires: hand over to the requested drive direction.
    if ((state == ST_DEAD) && (cnt == DEAD_CNT)) begin
      state_nxt    = (cur_dir == DIR_B) ? ST_DRIVE_B : ST_DRIVE_A;
      last_dir_nxt = cur_dir;
    end

    // Period boundary: the incoming duty decides the next period's mode.
    // last_dir survives OFF periods so a reversal through zero still waits.
    if (period_end) begin
      if (new_dir == DIR_NONE) begin
        state_nxt = ST_OFF;
      end else if ((last_dir_nxt != DIR_NONE) && (new_dir != last_dir_nxt)) begin
        state_nxt = ST_DEAD;
      end else begin
        state_nxt    = (new_dir == DIR_B) ? ST_DRIVE_B : ST_DRIVE_A;
        last_dir_nxt = new_dir;
      end
    end
  end

  assign bus.CH_A      = ch_a;
  assign bus.CH_B      = ch_b;
  assign bus.prd_strt  = prd_strt;
  assign bus.duty_actv = duty_actv;

endmodule
`default_nettype wire

// File: tb/tb_pwm_drv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_drv
//  Description : Directed self-checking bench for pwm_drv (CNT_W=13,
//                DEADTIME=16). Each period is walked cycle by cycle from
//                cnt==0, counting on-cycles per channel against hand values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_drv;

  localparam int PERIOD = 8192;
  localparam int NONE   = -1;

  logic clk;
  logic rst;

  pwm_drv_if bus ();

  pwm_drv #(
    .CNT_W    (13),
    .DEADTIME (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // Per-period observations gathered by run_period.
  int          a_on;
  int          b_on;
  int          a_first;
  int          b_first;
  int          ovl;
  int          strt_in;
  logic [13:0] da0;
  logic [13:0] da_last;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Entered at the negedge of a cycle with cnt==0; walks len cycles, sampling
  // on negedges and placing up to two duty writes at given cycle indices.
  task automatic run_period(input logic [13:0] w0, input int t0,
                            input logic [13:0] w1, input int t1,
                            input int len);
    a_on = 0; b_on = 0; a_first = NONE; b_first = NONE;
    ovl = 0; strt_in = 0;
    da0 = bus.duty_actv;
    da_last = 'x;
    for (int i = 0; i < len; i++) begin
      if (bus.CH_A === 1'b1) begin
        a_on++;
        if (a_first == NONE) a_first = i;
      end
      if (bus.CH_B === 1'b1) begin
        b_on++;
        if (b_first == NONE) b_first = i;
      end
      if ((bus.CH_A === 1'b1) && (bus.CH_B === 1'b1)) ovl++;
      if ((i > 0) && (bus.prd_strt === 1'b1)) strt_in++;
      da_last = bus.duty_actv;
      bus.wrt_duty = 1'b0;
      if (i == t0) begin bus.duty = w0; bus.wrt_duty = 1'b1; end
      if (i == t1) begin bus.duty = w1; bus.wrt_duty = 1'b1; end
      @(negedge clk);
    end
    bus.wrt_duty = 1'b0;
  endtask

  task automatic check_period(input string p, input int ea, input int eb,
                              input int efa, input int efb,
                              input logic [13:0] eda0);
    chk({p, "_duty_actv"}, 32'(da0), 32'(eda0));
    chk({p, "_a_on"}, a_on, ea);
    chk({p, "_b_on"}, b_on, eb);
    chk({p, "_a_first"}, a_first, efa);
    chk({p, "_b_first"}, b_first, efb);
    chk({p, "_overlap"}, ovl, 0);
    chk({p, "_strt_inside"}, strt_in, 0);
    chk({p, "_strt_next"}, 32'(bus.prd_strt), 1);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.duty     = 14'd0;
    bus.wrt_duty = 1'b0;

    // Reset held for two cycles: everything low, no period pulse.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ch_a", 32'(bus.CH_A), 0);
      chk("rst_ch_b", 32'(bus.CH_B), 0);
      chk("rst_prd_strt", 32'(bus.prd_strt), 0);
      chk("rst_duty_actv", 32'(bus.duty_actv), 0);
    end
    rst = 1'b0;

    // P0: idle period; a mid-period write must not take effect yet.
    run_period(14'h0800, 4000, 14'h0, NONE, PERIOD);
    chk("p0_duty_actv_end", 32'(da_last), 0);
    check_period("p0", 0, 0, NONE, NONE, 14'h0000);

    // P1: +0x0800 from reset drives A directly; two writes, last one wins.
    run_period(14'h0200, 1000, 14'h0300, 5000, PERIOD);
    check_period("p1", 2048, 0, 1, NONE, 14'h0800);

    // P2: +0x0300; a write on the final count goes straight to duty_actv.
    run_period(14'h0100, 8191, 14'h0, NONE, PERIOD);
    check_period("p2", 768, 0, 1, NONE, 14'h0300);

    // P3: +0x0100 -> 256 on-cycles.
    run_period(14'h3800, 300, 14'h0, NONE, PERIOD);
    check_period("p3", 256, 0, 1, NONE, 14'h0100);

    // P4: reversal to -2048: 16-cycle dead band, B on for 2032.
    run_period(14'h2000, 10, 14'h0, NONE, PERIOD);
    check_period("p4", 0, 2032, NONE, 17, 14'h3800);

    // P5: -8192 saturates to 8191, same direction so no dead band.
    run_period(14'h0000, 10, 14'h0, NONE, PERIOD);
    check_period("p5", 0, 8191, NONE, 1, 14'h2000);

    // P6: zero duty -> both channels off.
    run_period(14'h0400, 10, 14'h0, NONE, PERIOD);
    check_period("p6", 0, 0, NONE, NONE, 14'h0000);

    // P7: B -> 0 -> A still reverses through a dead band; reset at cnt=100.
    run_period(14'h0, NONE, 14'h0, NONE, 100);
    chk("p7_duty_actv", 32'(da0), 32'(14'h0400));
    chk("p7_a_first", a_first, 17);
    chk("p7_b_on", b_on, 0);
    chk("p7_ch_a_at_100", 32'(bus.CH_A), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ch_a", 32'(bus.CH_A), 0);
    chk("mid_rst_ch_b", 32'(bus.CH_B), 0);
    chk("mid_rst_duty_actv", 32'(bus.duty_actv), 0);
    chk("mid_rst_prd_strt", 32'(bus.prd_strt), 0);
    rst = 1'b0;

    // Counter restarted: next pulse exactly one full period later.
    run_period(14'h0, NONE, 14'h0, NONE, PERIOD);
    check_period("p8", 0, 0, NONE, NONE, 14'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
